// File: rtl/cursor_pkg.sv
// Shared constants and types for the cursor/brush controller.
// Direction bit positions, speed states and the axis decode helper.
package cursor_pkg;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    CRUISE
  } speed_state_e;

  // Opposing buttons cancel; returns -1, 0 or +1.
  function automatic logic signed [1:0] axis_dir(
    input logic dec,
    input logic inc
  );
    unique case ({inc, dec})
      2'b10:   axis_dir = 2'sd1;
      2'b01:   axis_dir = -2'sd1;
      default: axis_dir = 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cursor_press_latch.sv
// Rising-edge detector with a sticky pending flag, cleared on consume.
// fire_out includes a same-cycle edge so a tap coinciding with consume is kept.
module press_latch (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  input  logic consume_in,
  output logic fire_out
);

  logic btn_q;
  logic btn_d;
  logic pend_q;
  logic pend_d;
  logic rise;

  assign rise     = btn_in & ~btn_q;
  assign fire_out = pend_q | rise;

  always_comb begin
    btn_d  = btn_in;
    pend_d = consume_in ? 1'b0 : fire_out;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      btn_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      btn_q  <= btn_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Per-frame cursor position, colour and stroke width update with
// hold-to-accelerate motion and wrap or clamp screen edges.
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter  int SCREEN_W     = 640,
  parameter  int SCREEN_H     = 480,
  parameter  int N_COLORS     = 16,
  parameter  int MAX_STROKE   = 7,
  parameter  int MAX_SPEED    = 8,
  parameter  int ACCEL_FRAMES = 4,
  parameter  int WRAP         = 0,
  localparam int X_W  = $clog2(SCREEN_W),
  localparam int Y_W  = $clog2(SCREEN_H),
  localparam int C_W  = $clog2(N_COLORS),
  localparam int S_W  = $clog2(MAX_STROKE + 1),
  localparam int SP_W = $clog2(MAX_SPEED + 1)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            nf_in,
  input  logic [3:0]      pos_con_in,
  input  logic            col_con_in,
  input  logic            sw_con_in,
  output logic [X_W-1:0]  cursor_loc_x,
  output logic [Y_W-1:0]  cursor_loc_y,
  output logic [C_W-1:0]  cursor_color,
  output logic [S_W-1:0]  stroke_width,
  output logic [SP_W-1:0] speed_out
);

  localparam int XS  = X_W + 1;
  localparam int YS  = Y_W + 1;
  localparam int H_W = $clog2(ACCEL_FRAMES + 1);

  speed_state_e   state_q, state_d;
  logic           nf_q, nf_d;
  logic [SP_W-1:0] spd_q, spd_d;
  logic [H_W-1:0] cnt_q, cnt_d;
  logic [H_W-1:0] cnt_nxt;
  logic [X_W-1:0] x_q, x_d, x_mv;
  logic [Y_W-1:0] y_q, y_d, y_mv;
  logic [C_W-1:0] c_q, c_d;
  logic [S_W-1:0] w_q, w_d;

  logic fe;
  logic fire_c;
  logic fire_w;
  logic moving;
  logic signed [1:0] dx;
  logic signed [1:0] dy;
  logic signed [XS-1:0] x_mag, x_delta, x_sum;
  logic signed [YS-1:0] y_mag, y_delta, y_sum;

  assign fe     = nf_in & ~nf_q;
  assign dx     = axis_dir(pos_con_in[DIR_LEFT], pos_con_in[DIR_RIGHT]);
  assign dy     = axis_dir(pos_con_in[DIR_UP], pos_con_in[DIR_DOWN]);
  assign moving = (dx != 2'sd0) || (dy != 2'sd0);

  press_latch u_col (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .btn_in     (col_con_in),
    .consume_in (fe),
    .fire_out   (fire_c)
  );

  press_latch u_sw (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .btn_in     (sw_con_in),
    .consume_in (fe),
    .fire_out   (fire_w)
  );

  assign x_mag = $signed(XS'(spd_q));
  assign y_mag = $signed(YS'(spd_q));

  always_comb begin
    x_delta = '0;
    y_delta = '0;
    if (dx == 2'sd1) x_delta = x_mag;
    else if (dx == -2'sd1) x_delta = -x_mag;
    if (dy == 2'sd1) y_delta = y_mag;
    else if (dy == -2'sd1) y_delta = -y_mag;
  end

  assign x_sum = $signed({1'b0, x_q}) + x_delta;
  assign y_sum = $signed({1'b0, y_q}) + y_delta;

  if (WRAP != 0) begin : g_wrap
    localparam logic signed [XS-1:0] X_EXT = XS'(SCREEN_W);
    localparam logic signed [YS-1:0] Y_EXT = YS'(SCREEN_H);
    always_comb begin
      if (x_sum[XS-1]) x_mv = X_W'(x_sum + X_EXT);
      else if (x_sum >= X_EXT) x_mv = X_W'(x_sum - X_EXT);
      else x_mv = X_W'(x_sum);
      if (y_sum[YS-1]) y_mv = Y_W'(y_sum + Y_EXT);
      else if (y_sum >= Y_EXT) y_mv = Y_W'(y_sum - Y_EXT);
      else y_mv = Y_W'(y_sum);
    end
  end else begin : g_clamp
    localparam logic signed [XS-1:0] X_LAST = XS'(SCREEN_W - 1);
    localparam logic signed [YS-1:0] Y_LAST = YS'(SCREEN_H - 1);
    always_comb begin
      if (x_sum[XS-1]) x_mv = '0;
      else if (x_sum > X_LAST) x_mv = X_W'(X_LAST);
      else x_mv = X_W'(x_sum);
      if (y_sum[YS-1]) y_mv = '0;
      else if (y_sum > Y_LAST) y_mv = Y_W'(Y_LAST);
      else y_mv = Y_W'(y_sum);
    end
  end

  always_comb begin
    nf_d    = nf_in;
    state_d = state_q;
    spd_d   = spd_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    w_d     = w_q;
    // The entering frame counts as the first held frame.
    cnt_nxt = (state_q == IDLE) ? H_W'(1) : cnt_q + H_W'(1);
    if (fe) begin
      if (fire_c)
        c_d = (c_q == C_W'(N_COLORS - 1)) ? '0 : c_q + C_W'(1);
      if (fire_w)
        w_d = (w_q == S_W'(MAX_STROKE)) ? S_W'(1) : w_q + S_W'(1);
      if (!moving) begin
        state_d = IDLE;
        spd_d   = SP_W'(1);
        cnt_d   = '0;
      end else begin
        x_d = x_mv;
        y_d = y_mv;
        if (state_q != CRUISE) begin
          if (cnt_nxt == H_W'(ACCEL_FRAMES)) begin
            cnt_d = '0;
            if (spd_q != SP_W'(MAX_SPEED))
              spd_d = spd_q + SP_W'(1);
          end else begin
            cnt_d = cnt_nxt;
          end
          state_d = (spd_d == SP_W'(MAX_SPEED)) ? CRUISE : HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      nf_q    <= 1'b0;
      state_q <= IDLE;
      spd_q   <= SP_W'(1);
      cnt_q   <= '0;
      x_q     <= X_W'(SCREEN_W / 2);
      y_q     <= Y_W'(SCREEN_H / 2);
      c_q     <= '0;
      w_q     <= S_W'(1);
    end else begin
      nf_q    <= nf_d;
      state_q <= state_d;
      spd_q   <= spd_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      w_q     <= w_d;
    end
  end

  assign cursor_loc_x = x_q;
  assign cursor_loc_y = y_q;
  assign cursor_color = c_q;
  assign stroke_width = w_q;
  assign speed_out    = spd_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: clamp and wrap instances share stimulus.
// Table vectors plus hand sequences for acceleration, edges and reset.
module tb_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       nf = 1'b0;
  logic [3:0] pos = 4'b0;
  logic       col = 1'b0;
  logic       sw = 1'b0;

  logic [9:0] x_c, x_w;
  logic [8:0] y_c, y_w;
  logic [3:0] c_c, c_w;
  logic [2:0] w_c, w_w;
  logic [3:0] s_c, s_w;

  int n_pass = 0;
  int n_total = 0;

  int mx_c, my_c, mx_w, my_w, m_n, m_spd;

  always #5 clk = ~clk;

  cursor_ctrl #(.WRAP(0)) dut_c (
    .clk_in(clk), .rst_in(rst), .nf_in(nf), .pos_con_in(pos),
    .col_con_in(col), .sw_con_in(sw),
    .cursor_loc_x(x_c), .cursor_loc_y(y_c), .cursor_color(c_c),
    .stroke_width(w_c), .speed_out(s_c)
  );

  cursor_ctrl #(.WRAP(1)) dut_w (
    .clk_in(clk), .rst_in(rst), .nf_in(nf), .pos_con_in(pos),
    .col_con_in(col), .sw_con_in(sw),
    .cursor_loc_x(x_w), .cursor_loc_y(y_w), .cursor_color(c_w),
    .stroke_width(w_w), .speed_out(s_w)
  );

  typedef struct {
    logic [3:0] p;
    logic       c;
    logic       s;
    int         ex, ey, ec, ew, es;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int mv(input int p, input int d, input int ext,
                            input bit wr);
    int s;
    s = p + d;
    if (wr) begin
      if (s < 0) s = s + ext;
      else if (s >= ext) s = s - ext;
    end else begin
      if (s < 0) s = 0;
      else if (s > ext - 1) s = ext - 1;
    end
    return s;
  endfunction

  function automatic int spd_of(input int n);
    int v;
    v = 1 + n / 4;
    return (v > 8) ? 8 : v;
  endfunction

  task automatic model_fe(input logic [3:0] p);
    int ddx, ddy, sp;
    ddx = int'(p[0]) - int'(p[1]);
    ddy = int'(p[2]) - int'(p[3]);
    if (ddx == 0 && ddy == 0) begin
      m_n = 0;
    end else begin
      sp = spd_of(m_n);
      mx_c = mv(mx_c, ddx * sp, 640, 1'b0);
      my_c = mv(my_c, ddy * sp, 480, 1'b0);
      mx_w = mv(mx_w, ddx * sp, 640, 1'b1);
      my_w = mv(my_w, ddy * sp, 480, 1'b1);
      m_n++;
    end
    m_spd = spd_of(m_n);
  endtask

  task automatic model_reset();
    mx_c = 320; my_c = 240; mx_w = 320; my_w = 240;
    m_n = 0; m_spd = 1;
  endtask

  task automatic fe_pulse(input logic [3:0] p, input logic c,
                          input logic s);
    @(negedge clk);
    pos = p; col = c; sw = s; nf = 1'b1;
    @(negedge clk);
    nf = 1'b0; col = 1'b0; sw = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fe(input logic [3:0] p, input logic c,
                       input logic s);
    fe_pulse(p, c, s);
    model_fe(p);
  endtask

  task automatic chk_pos();
    chk("x_clamp", int'(x_c), mx_c);
    chk("y_clamp", int'(y_c), my_c);
    chk("x_wrap", int'(x_w), mx_w);
    chk("y_wrap", int'(y_w), my_w);
    chk("speed", int'(s_c), m_spd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; nf = 1'b0; pos = 4'b0; col = 1'b0; sw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 320, 240, 0, 1, 1};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, 321, 240, 1, 1, 1};
    tbl[2]  = '{4'b0001, 1'b0, 1'b1, 322, 240, 1, 2, 1};
    tbl[3]  = '{4'b1000, 1'b0, 1'b0, 322, 239, 1, 2, 1};
    tbl[4]  = '{4'b1001, 1'b0, 1'b0, 323, 238, 1, 2, 2};
    tbl[5]  = '{4'b0101, 1'b0, 1'b0, 325, 240, 1, 2, 2};
    tbl[6]  = '{4'b1100, 1'b0, 1'b0, 325, 240, 1, 2, 1};
    tbl[7]  = '{4'b0011, 1'b0, 1'b0, 325, 240, 1, 2, 1};
    tbl[8]  = '{4'b0010, 1'b0, 1'b0, 324, 240, 1, 2, 1};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 324, 240, 1, 2, 1};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 324, 240, 2, 3, 1};

    do_reset();
    chk("rst_x", int'(x_c), 320);
    chk("rst_y", int'(y_c), 240);
    chk("rst_color", int'(c_c), 0);
    chk("rst_width", int'(w_c), 1);
    chk("rst_speed", int'(s_c), 1);

    for (int i = 0; i < 11; i++) begin
      do_fe(tbl[i].p, tbl[i].c, tbl[i].s);
      chk($sformatf("vec%0d_x", i), int'(x_c), tbl[i].ex);
      chk($sformatf("vec%0d_y", i), int'(y_c), tbl[i].ey);
      chk($sformatf("vec%0d_col", i), int'(c_c), tbl[i].ec);
      chk($sformatf("vec%0d_wid", i), int'(w_c), tbl[i].ew);
      chk($sformatf("vec%0d_spd", i), int'(s_c), tbl[i].es);
    end

    // Twenty taps, one per frame, then three taps inside one frame.
    do_reset();
    for (int i = 0; i < 20; i++) do_fe(4'b0000, 1'b1, 1'b1);
    chk("tap20_color", int'(c_c), 4);
    chk("tap20_width", int'(w_c), 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); col = 1'b1; sw = 1'b1;
      @(negedge clk); col = 1'b0; sw = 1'b0;
    end
    chk("no_fe_color", int'(c_c), 4);
    do_fe(4'b0000, 1'b0, 1'b0);
    chk("tap3_color", int'(c_c), 5);
    chk("tap3_width", int'(w_c), 1);

    // Long nf_in pulse is a single frame event.
    @(negedge clk); pos = 4'b0001; nf = 1'b1;
    repeat (5) @(negedge clk);
    nf = 1'b0;
    @(negedge clk);
    model_fe(4'b0001);
    chk("long_nf_x", int'(x_c), 321);
    chk_pos();

    // Acceleration to the right, into the clamp / wrap edge.
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      do_fe(4'b0001, 1'b0, 1'b0);
      chk_pos();
      if (k == 40) chk("accel40_x", int'(x_c), 528);
      if (k == 40) chk("accel40_spd", int'(s_c), 8);
    end
    chk("clamp_right", int'(x_c), 639);
    chk("wrap_right", int'(x_w), 48);
    do_fe(4'b0000, 1'b0, 1'b0);
    chk("release_spd", int'(s_c), 1);

    // Upward hold into the top edge.
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      do_fe(4'b1000, 1'b0, 1'b0);
      chk_pos();
    end
    chk("clamp_top", int'(y_c), 0);
    chk("wrap_top", int'(y_w), 472);

    // Opposing vertical buttons never move nor accelerate.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      do_fe(4'b1100, 1'b0, 1'b0);
      chk("updown_y", int'(y_c), 240);
      chk("updown_spd", int'(s_c), 1);
    end
    do_fe(4'b1000, 1'b0, 1'b0);
    chk("after_updown_y", int'(y_c), 239);

    // Reset in the middle of a hold drops speed and pending taps.
    do_reset();
    for (int k = 0; k < 6; k++) do_fe(4'b0001, 1'b0, 1'b0);
    chk("prehold_x", int'(x_c), 328);
    chk("prehold_spd", int'(s_c), 2);
    @(negedge clk); col = 1'b1;
    @(negedge clk); col = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_x", int'(x_c), 320);
    chk("async_rst_y", int'(y_c), 240);
    chk("async_rst_spd", int'(s_c), 1);
    chk("async_rst_wid", int'(w_c), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_fe(4'b0001, 1'b0, 1'b0);
    chk("post_rst_x", int'(x_c), 321);
    chk("post_rst_color", int'(c_c), 0);
    chk_pos();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Parametrised cursor/brush controller for the drawing pipeline. It sits between the debounced user controls and the renderer. Once per frame, on the new-frame strobe, it updates the cursor position, colour index and stroke width. It adds three things over the fixed 640x480 controller: hold-to-accelerate motion, a selectable wrap or clamp edge mode, and latched button presses so that sub-frame taps are never lost.

## Interface
Parameters:
- SCREEN_W, 640, horizontal extent in pixels; X_W = $clog2(SCREEN_W)
- SCREEN_H, 480, vertical extent in pixels; Y_W = $clog2(SCREEN_H)
- N_COLORS, 16, number of palette entries; C_W = $clog2(N_COLORS)
- MAX_STROKE, 7, largest stroke width, minimum 1; S_W = $clog2(MAX_STROKE+1)
- MAX_SPEED, 8, pixels/frame ceiling of acceleration
- ACCEL_FRAMES, 4, consecutive held frames per speed step
- WRAP, 0, 0 = clamp at edges, 1 = wrap modulo extent

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- nf_in  input  1  new-frame strobe; a frame event is its rising edge
- pos_con_in  input  4  direction buttons: [3] up, [2] down, [1] left, [0] right
- col_con_in  input  1  colour-advance button, level
- sw_con_in  input  1  stroke-width-advance button, level
- cursor_loc_x  output  X_W  cursor column
- cursor_loc_y  output  Y_W  cursor row
- cursor_color  output  C_W  palette index
- stroke_width  output  S_W  brush width, range 1..MAX_STROKE
- speed_out  output  $clog2(MAX_SPEED+1)  current step size (debug/HUD)

## Operation
- Frame event (FE): a cycle with nf_in=1 and registered nf_prev=0. All architectural outputs change only on FE.
- Axis direction: up+down held together gives dy=0; left+right held together gives dx=0. Up decrements y; right increments x.
- Speed FSM, states IDLE, HOLD, CRUISE:
  - IDLE: speed=1, hold_cnt=0. On an FE with any direction held, the cursor moves and the FSM goes to HOLD.
  - HOLD: hold_cnt increments on each FE with a direction held. When hold_cnt reaches ACCEL_FRAMES, speed becomes min(speed+1, MAX_SPEED) and hold_cnt resets to 0. When speed reaches MAX_SPEED, the FSM goes to CRUISE.
  - Any state: an FE with pos_con_in==0 returns the FSM to IDLE with speed=1.
  - A step uses the speed held before that FE's update.
- Position arithmetic is done in X_W+1 / Y_W+1 bit signed form.
  - Clamp mode: the result saturates to [0, SCREEN_W-1] and [0, SCREEN_H-1].
  - Wrap mode: the result is taken modulo the extent. Example: x=2, step -5 gives SCREEN_W-3.
- Button latches: a rising edge on col_con_in or sw_con_in sets a pending flag. On FE, each pending flag is consumed and cleared.
  - Colour advance: (color+1) mod N_COLORS.
  - Width advance: width+1, with MAX_STROKE wrapping to 1.
  - Multiple edges between two FEs count as one advance.
  - An edge in the same cycle as an FE is applied at that FE.
- Buttons and motion are independent; both may apply on the same FE.

## Timing
- Reset values (asynchronous): cursor_loc_x=SCREEN_W/2, cursor_loc_y=SCREEN_H/2, cursor_color=0, stroke_width=1, speed_out=1, FSM=IDLE, pending flags and nf_prev cleared, button edge registers cleared.
- Latency: inputs sampled at the FE clock edge are visible on the outputs after that edge, i.e. one cycle.
- nf_in held high for several cycles produces exactly one FE.
- Reset asserted mid-hold discards speed, hold count and pending presses. The first FE after release behaves as from IDLE.
- No input handshake; inputs are assumed synchronous and debounced upstream.

## Structure
- cursor_pkg: direction bit index constants (DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0) and the speed-state enum (IDLE, HOLD, CRUISE).
- Sub-module press_latch: rising-edge detect plus a pending flag with a consume input. It is instantiated twice, for colour and width.
- Position update: one combinational step function per axis, selected by the WRAP generate.

## Test plan
- Reset, then FE with pos_con_in=0 -> x=320, y=240, color=0, width=1, speed_out=1.
- Twenty col/sw taps, one tap per FE -> color=4 (20 mod 16), width wraps 1..7 and reads 7. Then three taps inside one frame -> exactly one advance.
- pos_con_in=4'b0001, ACCEL_FRAMES=4, 40 FEs -> speed_out runs 1..8 and then holds 8. x matches the reference-model sum; release -> speed_out=1 on the next FE.
- Clamp: start x=635, hold right with speed 8 -> x=639. Hold up from y=3 -> y=0.
- WRAP=1: x=2, left at speed 5 -> x=637. y=478, down at speed 4 -> y=2.
- pos_con_in=4'b1100 for 10 FEs -> y unchanged, FSM stays IDLE. Reset asserted mid-HOLD, released -> all reset values, and the next held FE moves by 1.
